uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd2000000: clk cycles allowed in WAIT_FT before a frame is aborted.
REQ-002 SHALL have parameter GAP_CYC, default 8'd16: idle clk cycles inserted between frames.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_m, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req, input, 4: per-requester level request; requester i holds req[i] high until ack[i].
REQ-006 SHALL have port req_data, input, 256: frame payloads; requester i owns bits [64*i+63 : 64*i].
REQ-007 SHALL have port parity_en and parity_kind, input, 1 each: parity configuration, sampled per frame.
REQ-008 SHALL have port ack, output, 4: one-cycle pulse; payload of requester i latched.
REQ-009 SHALL have port done, output, 4: one-cycle pulse; frame of requester i completed.
REQ-010 SHALL have port err, output, 1, and err_id, output, 2: one-cycle timeout pulse, with the aborted requester index.
REQ-011 SHALL have port tx_data, output, 64 ([64:1]): payload to transmitter; tx_data[64:1] = req_data[64*g+63 : 64*g].
REQ-012 SHALL have ports tx_read (start pulse), tx_en (session enable), tx_parity_en and tx_parity_kind, output, 1 each.
REQ-013 SHALL have port ft, input, 1: transmitter finish flag; only its rising edge is significant.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, LOAD, START, WAIT_FT, DONE, GAP.
REQ-016 IDLE: if req != 0, SHALL pick grant g round-robin, searching upward from pointer ptr with wrap 3->0, and go to LOAD.
REQ-017 IDLE with req == 0 SHALL stay in IDLE; req is sampled only in IDLE.
REQ-018 LOAD: SHALL latch tx_data, tx_parity_en and tx_parity_kind, pulse ack[g], and go to START.
REQ-019 START: SHALL assert tx_read for exactly one cycle, set tx_en = 1, clear the timeout counter, and go to WAIT_FT.
REQ-020 WAIT_FT: tx_en and latched outputs SHALL hold; on a registered rising edge of ft, SHALL go to DONE.
REQ-021 WAIT_FT: when the counter reaches TIMEOUT-1 with no ft edge, SHALL pulse err, set err_id = g, and go to DONE without a done pulse.
REQ-022 DONE: SHALL drop tx_en, pulse done[g] (success only), set ptr = g+1 mod 4, and go to GAP.
REQ-023 GAP: SHALL count GAP_CYC cycles then go to IDLE; GAP_CYC = 0 SHALL go directly to IDLE.
REQ-024 Latency: req rise in IDLE -> ack 2 cycles later -> tx_read 3 cycles after req rise.
REQ-025 ft edge detection SHALL use ft registered once; ft high on entry to WAIT_FT SHALL NOT count as an edge; ft edges outside WAIT_FT SHALL be ignored.
REQ-026 Payload, parity and config changes after LOAD SHALL NOT affect the frame in progress.
REQ-027 ft edge and timeout in the same cycle: ft wins, and there SHALL be no err pulse.
REQ-028 A requester dropping req before grant SHALL NOT be granted; after ack, req level SHALL be ignored until the next IDLE.
REQ-029 A requester re-requesting at once SHALL get lower priority than all others pending, due to round-robin.
REQ-030 At most one bit of ack, done and grant SHALL be high at any time.

Reset
REQ-031 rst_m low SHALL asynchronously force: state IDLE, ptr 0, ack/done/err/err_id 0, tx_data 0, tx_read/tx_en/tx_parity_en/tx_parity_kind 0, busy 0, counters 0, ft register 0.
REQ-032 Reset during WAIT_FT SHALL drop tx_en immediately, and there SHALL be no done or err pulse for the aborted frame.
REQ-033 After rst_m rises, the first grant SHALL be evaluated on the first clk edge in IDLE.

Verification
REQ-034 Single request: req=4'b0100, payload 64'hDEADBEEF_01234567 -> ack=4'b0100 at +2, tx_read at +3, tx_data matches; ft pulse -> done=4'b0100, tx_en=0.
REQ-035 Round-robin: req=4'b1111 held, ft returned each frame -> grant order 0,1,2,3,0; frame starts separated by at least GAP_CYC idle cycles.
REQ-036 Timeout: TIMEOUT=100, ft held 0 -> err pulse with err_id = g exactly 100 cycles after tx_read; no done; next grant proceeds.
REQ-037 ft high before START and never toggles -> no false completion; timeout fires.
REQ-038 Reset in WAIT_FT -> tx_en=0 asynchronously, all outputs 0; re-request after release -> grant 0 first.
REQ-039 Payload and parity_kind changed right after ack -> tx_data and tx_parity_kind keep the latched values until DONE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one of four requester payloads at a time to a
// UART transmitter, waits for its finish flag (or a timeout) and spaces frames.
module uart_tx_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd2000000,
    parameter logic [7:0]  GAP_CYC = 8'd16
) (
    input  logic          clk,
    input  logic          rst_m,
    input  logic [3:0]    req,
    input  logic [255:0]  req_data,
    input  logic          parity_en,
    input  logic          parity_kind,
    input  logic          ft,
    output logic [3:0]    ack,
    output logic [3:0]    done,
    output logic          err,
    output logic [1:0]    err_id,
    output logic [64:1]   tx_data,
    output logic          tx_read,
    output logic          tx_en,
    output logic          tx_parity_en,
    output logic          tx_parity_kind,
    output logic          busy
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_FT,
        S_DONE,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic                ok_q, ok_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ft_q;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;
    logic [PTR_W-1:0]    err_id_q, err_id_d;
    logic [DATA_W:1]     tx_data_q, tx_data_d;
    logic                tx_read_q, tx_read_d;
    logic                tx_en_q, tx_en_d;
    logic                tx_par_en_q, tx_par_en_d;
    logic                tx_par_kind_q, tx_par_kind_d;
    logic                busy_q, busy_d;

    logic                pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic                ft_rise;

    // Round-robin search upward from ptr; descending loop lets the nearest requester win.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        idx        = ptr_q;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            idx = ptr_q + PTR_W'(k);
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    assign ft_rise = ft & ~ft_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        ok_d          = ok_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        done_d        = '0;
        err_d         = 1'b0;
        err_id_d      = err_id_q;
        tx_data_d     = tx_data_q;
        tx_read_d     = 1'b0;
        tx_en_d       = tx_en_q;
        tx_par_en_d   = tx_par_en_q;
        tx_par_kind_d = tx_par_kind_q;

        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d     = req_data[DATA_W*grant_q +: DATA_W];
                tx_par_en_d   = parity_en;
                tx_par_kind_d = parity_kind;
                ack_d         = 4'b0001 << grant_q;
                state_d       = S_START;
            end
            S_START: begin
                tx_read_d = 1'b1;
                tx_en_d   = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT_FT;
            end
            S_WAIT_FT: begin
                // A finish edge takes priority over a timeout landing in the same cycle.
                if (ft_rise) begin
                    ok_d    = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT - 24'd1) begin
                    ok_d     = 1'b0;
                    err_d    = 1'b1;
                    err_id_d = grant_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            S_DONE: begin
                tx_en_d = 1'b0;
                if (ok_q) begin
                    done_d = 4'b0001 << grant_q;
                end
                ptr_d   = grant_q + 2'd1;
                cnt_d   = '0;
                state_d = (GAP_CYC == 8'd0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC) - 24'd1) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_m) begin
        if (!rst_m) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            ok_q          <= 1'b0;
            cnt_q         <= '0;
            ft_q          <= 1'b0;
            ack_q         <= '0;
            done_q        <= '0;
            err_q         <= 1'b0;
            err_id_q      <= '0;
            tx_data_q     <= '0;
            tx_read_q     <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_par_en_q   <= 1'b0;
            tx_par_kind_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            ok_q          <= ok_d;
            cnt_q         <= cnt_d;
            ft_q          <= ft;
            ack_q         <= ack_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_id_q      <= err_id_d;
            tx_data_q     <= tx_data_d;
            tx_read_q     <= tx_read_d;
            tx_en_q       <= tx_en_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_par_kind_q <= tx_par_kind_d;
            busy_q        <= busy_d;
        end
    end

    assign ack            = ack_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_id         = err_id_q;
    assign tx_data        = tx_data_q;
    assign tx_read        = tx_read_q;
    assign tx_en          = tx_en_q;
    assign tx_parity_en   = tx_par_en_q;
    assign tx_parity_kind = tx_par_kind_q;
    assign busy           = busy_q;

endmodule
